// File: rtl/RSA_pkg.sv
// Shared RSA types: job payload, result word and the job-arbiter FSM encoding.
package RSA_pkg;

    localparam int unsigned KEY_W = 32;

    typedef logic [KEY_W-1:0] KeyType;

    typedef struct packed {
        KeyType msg;
        KeyType key;
        KeyType modulus;
    } RSAModIn;

    typedef KeyType RSAModOut;

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        ISSUE,
        WAIT,
        DELIVER
    } RSAArbState;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set request strictly after index `last`, wrapping around.
module rr_pick #(
    parameter  int unsigned N    = 4,
    localparam int unsigned ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last,
    output logic            any,
    output logic [ID_W-1:0] idx
);

    logic [ID_W-1:0] cand;

    // Scan offsets from farthest to nearest so the nearest requester after `last` wins.
    always_comb begin
        any  = |req;
        idx  = '0;
        cand = '0;
        for (int unsigned off = N; off >= 1; off--) begin
            cand = ID_W'((32'(last) + off) % N);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/rsa_job_arbiter.sv
// Round-robin job arbiter sharing one RSA modexp core among N_REQ requesters.
// Define RSA_JOB_ARBITER_STATS_EN to add the stat_jobs / stat_busy counters.
module rsa_job_arbiter
    import RSA_pkg::*;
#(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  RSAModIn [N_REQ-1:0]   req_in,
    output logic [N_REQ-1:0]      resp_valid,
    input  logic [N_REQ-1:0]      resp_ready,
    output RSAModOut              resp_data,
    output logic [ID_W-1:0]       resp_id,
    output logic                  core_valid,
    input  logic                  core_ready,
    output RSAModIn               core_in,
    input  logic                  core_out_valid,
    output logic                  core_out_ready,
    input  RSAModOut              core_out
`ifdef RSA_JOB_ARBITER_STATS_EN
    ,
    output logic [31:0]           stat_jobs,
    output logic [31:0]           stat_busy
`endif
);

    RSAArbState      state_q, state_d;
    logic [ID_W-1:0] grant_id_q, grant_id_d;
    logic [ID_W-1:0] last_grant_q, last_grant_d;
    logic [ID_W-1:0] resp_id_q, resp_id_d;
    RSAModIn         core_in_q, core_in_d;
    RSAModOut        resp_data_q, resp_data_d;

    logic            pick_any;
    logic [ID_W-1:0] pick_idx;

    rr_pick #(.N(N_REQ)) u_pick (
        .req  (req_valid),
        .last (last_grant_q),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_id_q   <= '0;
            last_grant_q <= ID_W'(N_REQ - 1);
            resp_id_q    <= '0;
            core_in_q    <= '0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            resp_id_q    <= resp_id_d;
            core_in_q    <= core_in_d;
            resp_data_q  <= resp_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        resp_id_d    = resp_id_q;
        core_in_d    = core_in_q;
        resp_data_d  = resp_data_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_id_d = pick_idx;
                    state_d    = ACCEPT;
                end
            end
            ACCEPT: begin
                // A dropped valid abandons the grant without touching fairness state.
                if (req_valid[grant_id_q]) begin
                    core_in_d = req_in[grant_id_q];
                    state_d   = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (core_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (core_out_valid) begin
                    resp_data_d = core_out;
                    resp_id_d   = grant_id_q;
                    state_d     = DELIVER;
                end
            end
            DELIVER: begin
                if (resp_ready[grant_id_q]) begin
                    last_grant_d = grant_id_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready      = '0;
        resp_valid     = '0;
        core_valid     = 1'b0;
        core_out_ready = 1'b0;
        case (state_q)
            ACCEPT:  req_ready[grant_id_q]  = 1'b1;
            ISSUE:   core_valid             = 1'b1;
            WAIT:    core_out_ready         = 1'b1;
            DELIVER: resp_valid[grant_id_q] = 1'b1;
            default: ;
        endcase
    end

    assign core_in   = core_in_q;
    assign resp_data = resp_data_q;
    assign resp_id   = resp_id_q;

`ifdef RSA_JOB_ARBITER_STATS_EN
    logic [31:0] stat_jobs_q, stat_jobs_d;
    logic [31:0] stat_busy_q, stat_busy_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_jobs_q <= '0;
            stat_busy_q <= '0;
        end else begin
            stat_jobs_q <= stat_jobs_d;
            stat_busy_q <= stat_busy_d;
        end
    end

    always_comb begin
        stat_jobs_d = stat_jobs_q;
        stat_busy_d = stat_busy_q;
        if (state_q == DELIVER && resp_ready[grant_id_q] && stat_jobs_q != '1) begin
            stat_jobs_d = stat_jobs_q + 32'd1;
        end
        if (state_q != IDLE && stat_busy_q != '1) begin
            stat_busy_d = stat_busy_q + 32'd1;
        end
    end

    assign stat_jobs = stat_jobs_q;
    assign stat_busy = stat_busy_q;
`endif

endmodule

// File: tb/tb_rsa_job_arbiter.sv
// Directed self-checking bench for rsa_job_arbiter with a 10-cycle behavioural modexp core.
module tb_rsa_job_arbiter;
    import RSA_pkg::*;

    localparam int unsigned N    = 4;
    localparam int unsigned ID_W = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_ready, resp_valid, resp_ready;
    RSAModIn [N-1:0] req_in;
    RSAModOut        resp_data;
    logic [ID_W-1:0] resp_id;
    logic            core_valid, core_ready, core_out_valid, core_out_ready;
    RSAModIn         core_in;
    RSAModOut        core_out;
`ifdef RSA_JOB_ARBITER_STATS_EN
    logic [31:0]     stat_jobs, stat_busy;
`endif

    rsa_job_arbiter #(.N_REQ(N)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_in         (req_in),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data      (resp_data),
        .resp_id        (resp_id),
        .core_valid     (core_valid),
        .core_ready     (core_ready),
        .core_in        (core_in),
        .core_out_valid (core_out_valid),
        .core_out_ready (core_out_ready),
        .core_out       (core_out)
`ifdef RSA_JOB_ARBITER_STATS_EN
        ,
        .stat_jobs      (stat_jobs),
        .stat_busy      (stat_busy)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic RSAModIn mk(input int unsigned m, input int unsigned k, input int unsigned n);
        return {KeyType'(m), KeyType'(k), KeyType'(n)};
    endfunction

    function automatic RSAModOut modexp(input RSAModIn j);
        logic [63:0] r, b;
        r = 64'd1;
        b = 64'(j.msg % j.modulus);
        for (int i = 0; i < 32; i++) begin
            if (j.key[i]) r = (r * b) % 64'(j.modulus);
            b = (b * b) % 64'(j.modulus);
        end
        return r[31:0];
    endfunction

    // Requester sources: valid stays high while issued jobs exceed accepted ones.
    int unsigned jobs_req [N];
    int unsigned accepted [N];
    always_comb begin
        for (int i = 0; i < N; i++) req_valid[i] = accepted[i] < jobs_req[i];
    end

    logic        cr_en;
    logic        core_busy;
    int unsigned core_cnt;
    RSAModIn     core_job;
    assign core_ready = cr_en & ~core_busy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_busy      <= 1'b0;
            core_out_valid <= 1'b0;
            core_cnt       <= 0;
            core_out       <= '0;
            core_job       <= '0;
        end else begin
            if (core_valid && core_ready) begin
                core_busy <= 1'b1;
                core_cnt  <= 10;
                core_job  <= core_in;
            end else if (core_busy && !core_out_valid) begin
                if (core_cnt == 1) begin
                    core_out_valid <= 1'b1;
                    core_out       <= modexp(core_job);
                end
                core_cnt <= core_cnt - 1;
            end
            if (core_out_valid && core_out_ready) begin
                core_out_valid <= 1'b0;
                core_busy      <= 1'b0;
            end
        end
    end

    int unsigned gnt_log  [64];
    int unsigned del_id   [64];
    RSAModOut    del_data [64];
    logic [N-1:0] del_vec [64];
    int unsigned n_gnt = 0, n_del = 0, cv_cycles = 0, busy_cycles = 0;

    initial begin
        for (int i = 0; i < N; i++) accepted[i] = 0;
    end

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    accepted[i] <= accepted[i] + 1;
                    if (n_gnt < 64) gnt_log[n_gnt] <= i;
                    n_gnt <= n_gnt + 1;
                end
            end
            if (|(resp_valid & resp_ready)) begin
                if (n_del < 64) begin
                    del_id[n_del]   <= int'(resp_id);
                    del_data[n_del] <= resp_data;
                    del_vec[n_del]  <= resp_valid;
                end
                n_del <= n_del + 1;
            end
            if (core_valid) cv_cycles <= cv_cycles + 1;
            if (|req_ready || core_valid || core_out_ready || |resp_valid)
                busy_cycles <= busy_cycles + 1;
        end
    end

    task automatic wait_del(input int unsigned target, input string tag);
        for (int c = 0; c < 400; c++) begin
            if (n_del >= target) break;
            @(posedge clk); #1;
        end
        chk(tag, n_del, target);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string pfx);
        chk({pfx, "_req_ready"},  req_ready, '0);
        chk({pfx, "_resp_valid"}, resp_valid, '0);
        chk({pfx, "_core_valid"}, core_valid, 0);
        chk({pfx, "_core_oready"}, core_out_ready, 0);
        chk({pfx, "_core_in"},    core_in, '0);
        chk({pfx, "_resp_data"},  resp_data, '0);
        chk({pfx, "_resp_id"},    resp_id, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int unsigned g0, d0, cv0, b0;
        int unsigned m2 [4];
        int unsigned r2 [4];
        m2 = '{2, 3, 5, 7};
        r2 = '{8, 27, 24, 40};

        rst        = 1'b1;
        cr_en      = 1'b1;
        resp_ready = '1;
        req_in     = '0;
        for (int i = 0; i < N; i++) jobs_req[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("rst");
        rst = 1'b0;

        // Single job from requester 0
        req_in[0] = mk(4, 13, 497);
        cv0 = cv_cycles;
        jobs_req[0] = 1;
        wait_del(1, "t1_done");
        chk("t1_gnt",  gnt_log[0], 0);
        chk("t1_vec",  del_vec[0], 4'b0001);
        chk("t1_data", del_data[0], 445);
        chk("t1_id",   del_id[0], 0);
        chk("t1_cv_cycles", cv_cycles - cv0, 1);

        // All four requesters together from a fresh reset
        do_reset();
        g0 = n_gnt; d0 = n_del;
        for (int i = 0; i < N; i++) begin
            req_in[i]   = mk(m2[i], 3, 101);
            jobs_req[i] = jobs_req[i] + 1;
        end
        wait_del(d0 + 4, "t2_done");
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t2_gnt%0d", k),  gnt_log[g0 + k], k);
            chk($sformatf("t2_id%0d", k),   del_id[d0 + k], k);
            chk($sformatf("t2_data%0d", k), del_data[d0 + k], r2[k]);
            chk($sformatf("t2_vec%0d", k),  del_vec[d0 + k], 4'b0001 << k);
        end

        // Back-pressure on both the core input and the result channel
        g0 = n_gnt; d0 = n_del;
        cr_en      = 1'b0;
        resp_ready = 4'b1101;
        req_in[1]  = mk(6, 5, 1000);
        req_in[3]  = mk(9, 2, 50);
        jobs_req[1] = jobs_req[1] + 1;
        for (int c = 0; c < 20; c++) begin
            if (core_valid) break;
            @(posedge clk); #1;
        end
        chk("t3_issue", core_valid, 1);
        jobs_req[3] = jobs_req[3] + 1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("t3_core_in%0d", c), core_in, mk(6, 5, 1000));
            chk($sformatf("t3_cv%0d", c), core_valid, 1);
            chk($sformatf("t3_ngnt_a%0d", c), n_gnt, g0 + 1);
        end
        cr_en = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (resp_valid != '0) break;
            @(posedge clk); #1;
        end
        chk("t3_rvalid", resp_valid, 4'b0010);
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            chk($sformatf("t3_rdata%0d", c), resp_data, 776);
            chk($sformatf("t3_rvec%0d", c), resp_valid, 4'b0010);
            chk($sformatf("t3_ngnt_b%0d", c), n_gnt, g0 + 1);
        end
        resp_ready = '1;
        wait_del(d0 + 2, "t3_done");
        chk("t3_gnt0",  gnt_log[g0], 1);
        chk("t3_gnt1",  gnt_log[g0 + 1], 3);
        chk("t3_data0", del_data[d0], 776);
        chk("t3_data1", del_data[d0 + 1], 31);
        chk("t3_id1",   del_id[d0 + 1], 3);

        // Fairness between requesters 1 and 3
        g0 = n_gnt; d0 = n_del;
        req_in[1] = mk(3, 4, 100);
        req_in[3] = mk(2, 10, 1000);
        jobs_req[1] = jobs_req[1] + 3;
        jobs_req[3] = jobs_req[3] + 3;
        wait_del(d0 + 6, "t4_done");
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t4_gnt%0d", k),  gnt_log[g0 + k], (k % 2 == 0) ? 1 : 3);
            chk($sformatf("t4_data%0d", k), del_data[d0 + k], (k % 2 == 0) ? 81 : 24);
        end

        // Asynchronous reset while waiting on the core
        req_in[0] = mk(5, 3, 7);
        jobs_req[0] = jobs_req[0] + 1;
        for (int c = 0; c < 30; c++) begin
            if (core_out_ready) break;
            @(posedge clk); #1;
        end
        chk("t5_in_wait", core_out_ready, 1);
        #2 rst = 1'b1;
        #1;
        chk_idle_outputs("t5_async");
        req_in[2] = mk(5, 3, 7);
        jobs_req[2] = jobs_req[2] + 1;
        @(posedge clk);
        #1 rst = 1'b0;
        g0 = n_gnt; d0 = n_del;
        wait_del(d0 + 1, "t5_done");
        chk("t5_gnt",  gnt_log[g0], 2);
        chk("t5_data", del_data[d0], 6);
        chk("t5_id",   del_id[d0], 2);
        chk("t5_vec",  del_vec[d0], 4'b0100);

`ifdef RSA_JOB_ARBITER_STATS_EN
        do_reset();
        b0 = busy_cycles; d0 = n_del;
        req_in[0] = mk(4, 13, 497);
        jobs_req[0] = jobs_req[0] + 3;
        wait_del(d0 + 3, "t6_done");
        @(posedge clk); #1;
        chk("t6_stat_jobs", stat_jobs, 3);
        chk("t6_stat_busy", stat_busy, busy_cycles - b0);
`else
        b0 = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rsa_job_arbiter.md
Name: rsa_job_arbiter

Overview:
- Shares one RSA modular-exponentiation core between N_REQ independent requesters.
- Each requester has its own valid/ready job channel and result channel.
- Fair round-robin grant; one job in flight at a time.
- Job payload is latched and issued to the core; the core result is captured and returned only to the requester that owns the job.
- Sits between host-side job sources and the single RSA top-level core instance.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- ID_W, $clog2(N_REQ), grant index width (localparam, derived).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  N_REQ  per-requester job valid
- req_ready  out  N_REQ  per-requester job accept (one-hot or zero)
- req_in  in  N_REQ x RSAModIn  per-requester {msg, key, modulus}
- resp_valid  out  N_REQ  per-requester result valid (one-hot or zero)
- resp_ready  in  N_REQ  per-requester result accept
- resp_data  out  RSAModOut  result, shared bus, meaningful only where resp_valid set
- resp_id  out  ID_W  owner index of current result
- core_valid  out  1  job valid to RSA core
- core_ready  in  1  RSA core input ready
- core_in  out  RSAModIn  latched job payload
- core_out_valid  in  1  RSA core result valid
- core_out_ready  out  1  result accept to core
- core_out  in  RSAModOut  RSA core result

Behaviour:
- Reset (rst=1, async): state=IDLE, grant_id=0, last_grant=N_REQ-1 so requester 0 wins first. All outputs are 0: req_ready, core_valid, core_in, core_out_ready, resp_valid, resp_data, resp_id.
- FSM states: IDLE -> ACCEPT -> ISSUE -> WAIT -> DELIVER -> IDLE.
- IDLE: if any req_valid, register grant_id = first set bit scanning from last_grant+1 upward with wrap-around, then go to ACCEPT. Otherwise stay.
- ACCEPT: req_ready[grant_id]=1 (registered, no comb path from req_valid).
  - Requesters hold valid until ready.
  - If req_valid[grant_id]=1, the transfer occurs: latch req_in[grant_id] into core_in, then go to ISSUE.
  - If the requester dropped valid (protocol violation), return to IDLE with no state change to last_grant.
- ISSUE: core_valid=1, core_in stable. On core_valid&&core_ready, go to WAIT; core_valid falls next cycle.
- WAIT: core_out_ready=1. On core_out_valid, latch core_out into resp_data, set resp_id=grant_id, go to DELIVER.
- DELIVER: resp_valid[grant_id]=1, resp_data held stable. On resp_ready[grant_id], clear resp_valid, set last_grant=grant_id, go to IDLE.
- Minimum arbiter overhead: 1 (IDLE) + 1 (ACCEPT) + 1 (ISSUE) + core latency + 1 (WAIT capture) + 1 (DELIVER).
- Back-to-back jobs: requests arriving during a job are held by their sources. The next grant is evaluated in IDLE only.
- Fairness: a requester that just completed has lowest priority next round. With all N_REQ asserting, grants cycle 0,1,...,N_REQ-1,0.
- resp_ready on non-owner bits is ignored. req_valid changes outside ACCEPT are ignored.
- Single requester active: repeatedly granted with no idle bubble beyond the FSM cycles.
- Reset mid-operation: FSM aborts immediately and outputs return to reset values. The core shares rst, so no stale result can return after reset.

Optional Feature:
- Macro: RSA_JOB_ARBITER_STATS_EN.
- Defined: adds output ports stat_jobs (32 bits) and stat_busy (32 bits).
  - stat_jobs increments on each DELIVER handshake.
  - stat_busy increments every cycle state!=IDLE.
  - Both saturate at all-ones and reset to 0.
- Undefined: ports and counters absent. Functional behaviour otherwise identical.

Decomposition:
- RSA_pkg gains typedef enum logic [2:0] RSAArbState {IDLE, ACCEPT, ISSUE, WAIT, DELIVER}.
- RSAModIn, RSAModOut and KeyType are reused from RSA_pkg unchanged.
- One sub-module: rr_pick (combinational, parameter N), inputs {req vector, last index}, outputs {any, index}, rotate-and-priority-encode.

Test Plan:
- Single job: req0 {msg=4, key=13, modulus=497}, behavioural core model (msg^key mod N, 10-cycle latency) -> resp_valid=4'b0001, resp_data=445, resp_id=0; core_valid high exactly one cycle when core_ready=1.
- All four requesters valid with distinct msgs 2,3,5,7, key=3, modulus=101 -> grant order 0,1,2,3, results 8,27,24,40 each on its own resp_valid bit.
- Back-pressure: core_ready low 5 cycles, then resp_ready[grant] low 7 cycles -> core_in and resp_data stable throughout, no second grant issued.
- Fairness: req1 and req3 always valid -> grants alternate 1,3,1,3 across 6 jobs.
- Async reset asserted while in WAIT -> all outputs 0 within same cycle. After release with req2 valid, first grant is 2 (last_grant reset to N_REQ-1) and result is correct.
- With RSA_JOB_ARBITER_STATS_EN: after 3 completed jobs, stat_jobs=3 and stat_busy equals counted non-IDLE cycles.
